// File: rtl/img_window_gen_if.sv
// Pixel-in / patch-out handshake bundle for img_window_gen.
interface img_window_gen_if #(
  parameter int unsigned data_width = 8,
  parameter int unsigned out_len    = 32
);
  logic [2:0]                            k;
  logic                                  stride;
  logic [data_width-1:0]                 pix_in;
  logic                                  pix_valid;
  logic                                  pix_ready;
  logic [out_len-1:0][data_width-1:0]    out_patch;
  logic                                  out_valid;
  logic                                  out_ready;
  logic                                  out_last;
  logic                                  err;

  // Upstream/downstream environment side.
  modport master (
    output k, stride, pix_in, pix_valid, out_ready,
    input  pix_ready, out_patch, out_valid, out_last, err
  );

  // Window generator side.
  modport slave (
    input  k, stride, pix_in, pix_valid, out_ready,
    output pix_ready, out_patch, out_valid, out_last, err
  );
endinterface

// File: rtl/img_window_gen.sv
// Buffers one raster frame, then emits every k x k window (stride 1 or 2)
// as a flattened, zero-padded patch over a valid/ready handshake.
module img_window_gen #(
  parameter int unsigned data_width = 8,
  parameter int unsigned img_size   = 5,
  parameter int unsigned out_len    = 32
) (
  input  logic           clk,
  input  logic           rst,
  img_window_gen_if.slave bus
);
  localparam int unsigned NPIX = img_size * img_size;
  localparam int unsigned CW   = $clog2(NPIX);
  localparam int unsigned PW   = $clog2(img_size);
  localparam int unsigned OW   = $clog2(out_len);

  localparam logic [0:0] LOAD = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  typedef logic [out_len-1:0][data_width-1:0] patch_t;

  logic [0:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2:0]            k_q, k_d;
  logic                  s2_q, s2_d;
  logic [PW-1:0]         r_q, r_d, c_q, c_d;
  logic                  pix_ready_q, pix_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic                  err_q, err_d;
  patch_t                out_patch_q, out_patch_d;
  logic [data_width-1:0] frame_q [NPIX];
  logic [data_width-1:0] frame_d [NPIX];
  logic                  load_patch;
  logic                  xfer;
  int unsigned           step_q, lim_q, lim_d, pmax_d;
  logic [OW-1:0]         pidx;
  logic [CW-1:0]         fidx;

  assign xfer   = bus.pix_valid && pix_ready_q;
  assign step_q = s2_q ? 32'd2 : 32'd1;
  assign lim_q  = img_size - 32'(k_q);

  assign bus.pix_ready = pix_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_patch = out_patch_q;
  assign bus.err       = err_q;

  // Control next-state: frame loading, k validation and window stepping.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    s2_d        = s2_q;
    r_d         = r_q;
    c_d         = c_q;
    pix_ready_d = pix_ready_q;
    out_valid_d = out_valid_q;
    err_d       = 1'b0;
    load_patch  = 1'b0;
    frame_d     = frame_q;
    if (state_q == LOAD) begin
      pix_ready_d = 1'b1;
      if (xfer) begin
        frame_d[cnt_q] = bus.pix_in;
        if (cnt_q == CW'(NPIX - 1)) begin
          k_d   = bus.k;
          s2_d  = bus.stride;
          r_d   = '0;
          c_d   = '0;
          cnt_d = '0;
          if (bus.k == 3'd0 || 32'(bus.k) > img_size) begin
            err_d = 1'b1;
          end else begin
            state_d     = EMIT;
            pix_ready_d = 1'b0;
            out_valid_d = 1'b1;
            load_patch  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end else if (out_valid_q && bus.out_ready) begin
      if (out_last_q) begin
        state_d     = LOAD;
        out_valid_d = 1'b0;
        pix_ready_d = 1'b1;
        cnt_d       = '0;
      end else begin
        if (32'(c_q) + step_q <= lim_q) begin
          c_d = PW'(32'(c_q) + step_q);
        end else begin
          c_d = '0;
          r_d = PW'(32'(r_q) + step_q);
        end
        load_patch = 1'b1;
      end
    end
  end

  // Patch and last flag for the upcoming window position; built from frame_d
  // so the first patch can include the pixel written on the final transfer.
  always_comb begin
    out_patch_d = '0;
    pidx        = '0;
    fidx        = '0;
    lim_d       = img_size - 32'(k_d);
    pmax_d      = s2_d ? (lim_d & ~32'd1) : lim_d;
    out_last_d  = (32'(r_d) == pmax_d) && (32'(c_d) == pmax_d);
    for (int unsigned i = 0; i < img_size; i++) begin
      for (int unsigned j = 0; j < img_size; j++) begin
        if (i < 32'(k_d) && j < 32'(k_d) &&
            32'(r_d) + i < img_size && 32'(c_d) + j < img_size) begin
          pidx = OW'(i * 32'(k_d) + j);
          fidx = CW'((32'(r_d) + i) * img_size + 32'(c_d) + j);
          out_patch_d[pidx] = frame_d[fidx];
        end
      end
    end
  end

  // Frame storage: only written by accepted pixels in LOAD, needs no reset.
  always_ff @(posedge clk) begin
    frame_q <= frame_d;
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      k_q         <= '0;
      s2_q        <= 1'b0;
      r_q         <= '0;
      c_q         <= '0;
      pix_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
      out_patch_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      s2_q        <= s2_d;
      r_q         <= r_d;
      c_q         <= c_d;
      pix_ready_q <= pix_ready_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      if (load_patch) begin
        out_patch_q <= out_patch_d;
        out_last_q  <= out_last_d;
      end else if (state_d == LOAD) begin
        out_last_q  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_img_window_gen.sv
// Self-checking bench for img_window_gen against a window-enumeration model.
module tb_img_window_gen;
  localparam int DW = 8;
  localparam int IS = 5;
  localparam int OL = 32;
  typedef logic [OL-1:0][DW-1:0] patch_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  img_window_gen_if #(.data_width(DW), .out_len(OL)) bus();
  img_window_gen #(.data_width(DW), .img_size(IS), .out_len(OL)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] fr [IS*IS];
  patch_t exp_p[$];
  patch_t got_p[$];
  logic   exp_l[$];
  logic   got_l[$];
  bit     timeout;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random;
    for (int p = 0; p < IS*IS; p++) fr[p] = DW'($urandom);
  endtask

  // Pushes the first n pixels of fr, optionally with random idle gaps.
  task automatic load_frame(input int n, input int kk, input int st, input bit gaps);
    for (int p = 0; p < n; p++) begin
      int guard = 0;
      bit was;
      if (gaps) begin
        repeat ($urandom_range(2)) begin
          bus.pix_valid = 1'b0;
          bus.pix_in    = DW'($urandom);
          step;
        end
      end
      bus.pix_valid = 1'b1;
      bus.pix_in    = fr[p];
      bus.k         = 3'(kk);
      bus.stride    = st[0];
      do begin
        was = bus.pix_ready;
        step;
        guard++;
      end while (!was && guard < 20);
      total++;
      if (!was) begin
        bad++;
        $display("FAIL load_wait pixel=%0d pix_ready=0 required=1", p);
      end
    end
    bus.pix_valid = 1'b0;
  endtask

  // Reference: enumerate window origins directly from k and stride.
  task automatic build_exp(input int kk, input int s);
    int np = (IS - kk) / s + 1;
    exp_p.delete();
    exp_l.delete();
    for (int pr = 0; pr < np; pr++) begin
      for (int pc = 0; pc < np; pc++) begin
        patch_t p = '0;
        for (int i = 0; i < kk; i++)
          for (int j = 0; j < kk; j++)
            p[5'(i*kk + j)] = fr[(pr*s + i)*IS + pc*s + j];
        exp_p.push_back(p);
        exp_l.push_back(pr == np-1 && pc == np-1);
      end
    end
  endtask

  // Collects accepted patches. mode 0: always ready; 1: random ready;
  // 2: random ready plus noise on k/stride.
  task automatic drain(input int mode, input int max_acc);
    int cyc = 0;
    bit rdy;
    got_p.delete();
    got_l.delete();
    timeout = 0;
    forever begin
      if (cyc >= 400) begin
        timeout = 1;
        break;
      end
      rdy = (mode == 0) ? 1'b1 : ($urandom_range(1) == 1);
      bus.out_ready = rdy;
      if (mode == 2) begin
        bus.k      = 3'($urandom);
        bus.stride = 1'($urandom);
      end
      cyc++;
      if (bus.out_valid && rdy) begin
        got_p.push_back(bus.out_patch);
        got_l.push_back(bus.out_last);
        step;
        if (got_l[$] || got_p.size() >= max_acc) break;
      end else begin
        step;
      end
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step;
    step;
    total++; if (bus.pix_ready !== 1'b0) begin bad++; $display("FAIL rst_pix_ready got=%b exp=0", bus.pix_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.out_last !== 1'b0) begin bad++; $display("FAIL rst_out_last got=%b exp=0", bus.out_last); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", bus.err); end
    total++; if (bus.out_patch !== '0) begin bad++; $display("FAIL rst_out_patch got=%h exp=0", bus.out_patch); end
    rst = 1'b0;
    step;
    total++; if (bus.pix_ready !== 1'b1) begin bad++; $display("FAIL post_rst_pix_ready got=%b exp=1", bus.pix_ready); end
  endtask

  task automatic test_raster(input int kk, input int st);
    for (int p = 0; p < IS*IS; p++) fr[p] = DW'(p);
    build_exp(kk, st ? 2 : 1);
    load_frame(IS*IS, kk, st, 1'b0);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL raster_latency k=%0d got=%b exp=1", kk, bus.out_valid); end
    total++; if (bus.pix_ready !== 1'b0) begin bad++; $display("FAIL raster_emit_ready k=%0d got=%b exp=0", kk, bus.pix_ready); end
    drain(0, 1000);
    total++; if (timeout) begin bad++; $display("FAIL raster_timeout k=%0d got=%0d patches", kk, got_p.size()); end
    total++; if (got_p.size() !== exp_p.size()) begin bad++; $display("FAIL raster_count k=%0d got=%0d exp=%0d", kk, got_p.size(), exp_p.size()); end
    for (int n = 0; n < got_p.size() && n < exp_p.size(); n++) begin
      total++; if (got_p[n] !== exp_p[n]) begin bad++; $display("FAIL raster_patch k=%0d n=%0d got=%h exp=%h", kk, n, got_p[n], exp_p[n]); end
      total++; if (got_l[n] !== exp_l[n]) begin bad++; $display("FAIL raster_last k=%0d n=%0d got=%b exp=%b", kk, n, got_l[n], exp_l[n]); end
    end
    total++; if (bus.pix_ready !== 1'b1 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL raster_back_to_load k=%0d ready=%b valid=%b exp ready=1 valid=0", kk, bus.pix_ready, bus.out_valid); end
  endtask

  task automatic test_backpressure;
    fill_random;
    build_exp(3, 1);
    load_frame(IS*IS, 3, 0, 1'b1);
    bus.out_ready = 1'b1;
    total++; if (bus.out_valid !== 1'b1 || bus.out_patch !== exp_p[0]) begin bad++; $display("FAIL bp_first valid=%b got=%h exp=%h", bus.out_valid, bus.out_patch, exp_p[0]); end
    step;
    bus.out_ready = 1'b0;
    repeat (3) begin
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid got=%b exp=1", bus.out_valid); end
      total++; if (bus.out_patch !== exp_p[1] || bus.out_last !== 1'b0) begin bad++; $display("FAIL bp_hold_patch got=%h last=%b exp=%h last=0", bus.out_patch, bus.out_last, exp_p[1]); end
      step;
    end
    drain(0, 1000);
    total++; if (got_p.size() !== exp_p.size() - 1) begin bad++; $display("FAIL bp_count got=%0d exp=%0d", got_p.size(), exp_p.size() - 1); end
    for (int n = 0; n < got_p.size() && n + 1 < exp_p.size(); n++) begin
      total++; if (got_p[n] !== exp_p[n+1] || got_l[n] !== exp_l[n+1]) begin bad++; $display("FAIL bp_patch n=%0d got=%h/%b exp=%h/%b", n+1, got_p[n], got_l[n], exp_p[n+1], exp_l[n+1]); end
    end
  endtask

  task automatic test_random;
    repeat (4) begin
      int kk = $urandom_range(1, IS);
      int st = $urandom_range(1);
      fill_random;
      build_exp(kk, st ? 2 : 1);
      load_frame(IS*IS, kk, st, 1'b1);
      drain(2, 1000);
      total++; if (timeout || got_p.size() !== exp_p.size()) begin bad++; $display("FAIL rnd_count k=%0d st=%0d got=%0d exp=%0d timeout=%0d", kk, st, got_p.size(), exp_p.size(), timeout); end
      for (int n = 0; n < got_p.size() && n < exp_p.size(); n++) begin
        total++; if (got_p[n] !== exp_p[n] || got_l[n] !== exp_l[n]) begin bad++; $display("FAIL rnd_patch k=%0d st=%0d n=%0d got=%h/%b exp=%h/%b", kk, st, n, got_p[n], got_l[n], exp_p[n], exp_l[n]); end
      end
    end
  endtask

  task automatic test_err;
    int bad_k[2] = '{6, 0};
    foreach (bad_k[t]) begin
      bit saw_valid = 0;
      bit saw_err   = 0;
      fill_random;
      load_frame(IS*IS, bad_k[t], 0, 1'b1);
      total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL err_pulse k=%0d got=%b exp=1", bad_k[t], bus.err); end
      total++; if (bus.out_valid !== 1'b0 || bus.pix_ready !== 1'b1) begin bad++; $display("FAIL err_state k=%0d valid=%b ready=%b exp valid=0 ready=1", bad_k[t], bus.out_valid, bus.pix_ready); end
      repeat (5) begin
        step;
        if (bus.out_valid) saw_valid = 1;
        if (bus.err) saw_err = 1;
      end
      total++; if (saw_valid || saw_err) begin bad++; $display("FAIL err_after k=%0d valid_seen=%b err_seen=%b exp 0/0", bad_k[t], saw_valid, saw_err); end
    end
    fill_random;
    build_exp(2, 2);
    load_frame(IS*IS, 2, 1, 1'b0);
    drain(0, 1000);
    total++; if (timeout || got_p.size() !== exp_p.size()) begin bad++; $display("FAIL err_next_count got=%0d exp=%0d", got_p.size(), exp_p.size()); end
    for (int n = 0; n < got_p.size() && n < exp_p.size(); n++) begin
      total++; if (got_p[n] !== exp_p[n] || got_l[n] !== exp_l[n]) begin bad++; $display("FAIL err_next_patch n=%0d got=%h/%b exp=%h/%b", n, got_p[n], got_l[n], exp_p[n], exp_l[n]); end
    end
  endtask

  task automatic test_reset_mid;
    fill_random;
    load_frame(7, 3, 0, 1'b0);
    rst = 1'b1;
    step;
    rst = 1'b0;
    step;
    fill_random;
    build_exp(3, 1);
    load_frame(IS*IS, 3, 0, 1'b0);
    drain(0, 4);
    total++; if (bus.out_valid !== 1'b1 || bus.out_patch !== exp_p[4]) begin bad++; $display("FAIL mid_fifth valid=%b got=%h exp=%h", bus.out_valid, bus.out_patch, exp_p[4]); end
    rst = 1'b1;
    step;
    total++; if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.pix_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ctrl valid=%b last=%b ready=%b exp 0/0/0", bus.out_valid, bus.out_last, bus.pix_ready); end
    total++; if (bus.out_patch !== '0) begin bad++; $display("FAIL mid_rst_patch got=%h exp=0", bus.out_patch); end
    rst = 1'b0;
    step;
    fill_random;
    build_exp(2, 1);
    load_frame(IS*IS, 2, 0, 1'b1);
    drain(1, 1000);
    total++; if (timeout || got_p.size() !== 16) begin bad++; $display("FAIL mid_count got=%0d exp=16", got_p.size()); end
    for (int n = 0; n < got_p.size() && n < exp_p.size(); n++) begin
      total++; if (got_p[n] !== exp_p[n] || got_l[n] !== exp_l[n]) begin bad++; $display("FAIL mid_patch n=%0d got=%h/%b exp=%h/%b", n, got_p[n], got_l[n], exp_p[n], exp_l[n]); end
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.k         = '0;
    bus.stride    = 1'b0;
    bus.pix_in    = '0;
    bus.pix_valid = 1'b0;
    bus.out_ready = 1'b0;
    test_reset;
    test_raster(3, 0);
    test_raster(3, 1);
    test_raster(5, 0);
    test_backpressure;
    test_random;
    test_err;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
